// File: rtl/wram_arbiter_if.sv
// CPU/RV request-response bundle for the WRAM arbiter, plus its priority control and status.
interface wram_arbiter_if;
    logic        i_wram_load_ongoing;

    logic        i_cpu_req;
    logic [15:0] i_cpu_addr;
    logic        i_cpu_we;
    logic [7:0]  i_cpu_wdata;
    logic        o_cpu_ack;
    logic [7:0]  o_cpu_rdata;
    logic        o_cpu_err;

    logic        i_rv_req;
    logic [22:0] i_rv_addr;
    logic        i_rv_we;
    logic [7:0]  i_rv_wdata;
    logic        o_rv_ack;
    logic [7:0]  o_rv_rdata;
    logic        o_rv_err;

    logic        o_busy;
    logic [15:0] o_conflict_cnt;

    modport slave (
        input  i_wram_load_ongoing,
        input  i_cpu_req, i_cpu_addr, i_cpu_we, i_cpu_wdata,
        output o_cpu_ack, o_cpu_rdata, o_cpu_err,
        input  i_rv_req, i_rv_addr, i_rv_we, i_rv_wdata,
        output o_rv_ack, o_rv_rdata, o_rv_err,
        output o_busy, o_conflict_cnt
    );

    modport master (
        output i_wram_load_ongoing,
        output i_cpu_req, i_cpu_addr, i_cpu_we, i_cpu_wdata,
        input  o_cpu_ack, o_cpu_rdata, o_cpu_err,
        output i_rv_req, i_rv_addr, i_rv_we, i_rv_wdata,
        input  o_rv_ack, o_rv_rdata, o_rv_err,
        input  o_busy, o_conflict_cnt
    );
endinterface

// File: rtl/wram_arbiter.sv
// Two-port (CPU / RV) arbiter in front of an 8 KiB WRAM, IDLE->ACCESS->RESP per access.
// Define WRAM_ARB_STATS_EN to enable the saturating conflict counter on o_conflict_cnt.
module wram_arbiter #(
    parameter logic [15:0] BASE_CPU   = 16'h6000,
    parameter logic [22:0] BASE_RV    = 23'h66000,
    parameter int unsigned WAIT_LIMIT = 4
) (
    input  logic          i_clk,
    input  logic          i_reset,
    wram_arbiter_if.slave bus
);
    localparam logic [3:0] LIMIT = 4'(WAIT_LIMIT);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      state;
    logic [7:0]  mem [0:8191];

    logic        grant_rv;
    logic [12:0] offset;
    logic        acc_we;
    logic [7:0]  acc_wdata;
    logic        acc_ok;
    logic [3:0]  wait_cnt;

    logic        cpu_ack, cpu_err, rv_ack, rv_err, busy;
    logic [7:0]  cpu_rdata, rv_rdata;

    logic [15:0] cpu_diff;
    logic [22:0] rv_diff;
    logic        cpu_in_win, rv_in_win;
    logic        both_req, prio_rv, pick_rv;

    // Modular subtraction: an address is in the window iff its distance from BASE fits 13 bits.
    assign cpu_diff   = bus.i_cpu_addr - BASE_CPU;
    assign rv_diff    = bus.i_rv_addr - BASE_RV;
    assign cpu_in_win = (cpu_diff[15:13] == 3'd0);
    assign rv_in_win  = (rv_diff[22:13] == 10'd0);

    always_comb begin
        both_req = bus.i_cpu_req & bus.i_rv_req;
        prio_rv  = bus.i_wram_load_ongoing;
        pick_rv  = bus.i_rv_req & ~bus.i_cpu_req;
        if (both_req)
            pick_rv = (wait_cnt == LIMIT) ? ~prio_rv : prio_rv;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state     <= IDLE;
            grant_rv  <= 1'b0;
            offset    <= '0;
            acc_we    <= 1'b0;
            acc_wdata <= '0;
            acc_ok    <= 1'b0;
            wait_cnt  <= '0;
            cpu_ack   <= 1'b0;
            cpu_err   <= 1'b0;
            cpu_rdata <= 8'h00;
            rv_ack    <= 1'b0;
            rv_err    <= 1'b0;
            rv_rdata  <= 8'h00;
            busy      <= 1'b0;
        end else begin
            cpu_ack <= 1'b0;
            cpu_err <= 1'b0;
            rv_ack  <= 1'b0;
            rv_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.i_cpu_req || bus.i_rv_req) begin
                        grant_rv  <= pick_rv;
                        offset    <= pick_rv ? rv_diff[12:0] : cpu_diff[12:0];
                        acc_we    <= pick_rv ? bus.i_rv_we : bus.i_cpu_we;
                        acc_wdata <= pick_rv ? bus.i_rv_wdata : bus.i_cpu_wdata;
                        acc_ok    <= pick_rv ? rv_in_win : cpu_in_win;
                        // Only a priority win over a waiting port ages the counter.
                        if (both_req && (pick_rv == prio_rv))
                            wait_cnt <= wait_cnt + 4'd1;
                        else
                            wait_cnt <= '0;
                        busy  <= 1'b1;
                        state <= ACCESS;
                    end
                end
                ACCESS: begin
                    state <= RESP;
                    if (grant_rv) begin
                        rv_ack   <= 1'b1;
                        rv_err   <= ~acc_ok;
                        rv_rdata <= !acc_ok ? 8'hFF : (acc_we ? acc_wdata : mem[offset]);
                    end else begin
                        cpu_ack   <= 1'b1;
                        cpu_err   <= ~acc_ok;
                        cpu_rdata <= !acc_ok ? 8'hFF : (acc_we ? acc_wdata : mem[offset]);
                    end
                end
                RESP: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // RAM contents survive reset; a write landing on a reset edge is dropped.
    always_ff @(posedge i_clk) begin
        if (!i_reset && state == ACCESS && acc_ok && acc_we)
            mem[offset] <= acc_wdata;
    end

`ifdef WRAM_ARB_STATS_EN
    logic [15:0] conflict_cnt;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            conflict_cnt <= '0;
        else if (state == IDLE && both_req && conflict_cnt != 16'hFFFF)
            conflict_cnt <= conflict_cnt + 16'd1;
    end

    assign bus.o_conflict_cnt = conflict_cnt;
`else
    assign bus.o_conflict_cnt = 16'h0000;
`endif

    assign bus.o_cpu_ack   = cpu_ack;
    assign bus.o_cpu_err   = cpu_err;
    assign bus.o_cpu_rdata = cpu_rdata;
    assign bus.o_rv_ack    = rv_ack;
    assign bus.o_rv_err    = rv_err;
    assign bus.o_rv_rdata  = rv_rdata;
    assign bus.o_busy      = busy;
endmodule

// File: tb/tb_wram_arbiter.sv
// Directed self-checking bench for wram_arbiter: latency, arbitration fairness, window errors, reset.
module tb_wram_arbiter;
    logic i_clk = 1'b0;
    logic i_reset;

    always #5 i_clk = ~i_clk;

    wram_arbiter_if bus();

    wram_arbiter dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .bus     (bus)
    );

`ifdef WRAM_ARB_STATS_EN
    localparam int STATS = 1;
`else
    localparam int STATS = 0;
`endif

    int checks   = 0;
    int failures = 0;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic tick;
        @(posedge i_clk);
        #1;
    endtask

    // Single-port transaction: hold req until ack, then drop it and let the FSM return to IDLE.
    task automatic applyStimulus(input bit use_rv, input logic [22:0] addr, input bit we,
                                 input logic [7:0] wdata, output logic [7:0] rdata,
                                 output logic err, output int latency);
        latency = -1;
        rdata   = 8'h00;
        err     = 1'b0;
        if (use_rv) begin
            bus.i_rv_req = 1'b1; bus.i_rv_addr = addr; bus.i_rv_we = we; bus.i_rv_wdata = wdata;
        end else begin
            bus.i_cpu_req = 1'b1; bus.i_cpu_addr = addr[15:0]; bus.i_cpu_we = we; bus.i_cpu_wdata = wdata;
        end
        for (int c = 1; c <= 20; c++) begin
            tick;
            if (use_rv ? bus.o_rv_ack : bus.o_cpu_ack) begin
                latency = c;
                rdata   = use_rv ? bus.o_rv_rdata : bus.o_cpu_rdata;
                err     = use_rv ? bus.o_rv_err : bus.o_cpu_err;
                break;
            end
        end
        bus.i_cpu_req = 1'b0;
        bus.i_rv_req  = 1'b0;
        tick;
    endtask

    // Both ports request in the same cycle; each drops its req on its own ack.
    task automatic runBoth(input bit load, input bit toggle,
                           input logic [15:0] c_addr, input bit c_we, input logic [7:0] c_wdata,
                           input logic [22:0] r_addr, input bit r_we, input logic [7:0] r_wdata,
                           output int cpu_cycle, output int rv_cycle,
                           output logic [7:0] c_rdata, output logic [7:0] r_rdata,
                           output logic c_err, output logic r_err, output int overlap);
        cpu_cycle = -1; rv_cycle = -1; overlap = 0;
        c_rdata = 8'h00; r_rdata = 8'h00; c_err = 1'b0; r_err = 1'b0;
        bus.i_wram_load_ongoing = load;
        bus.i_cpu_req = 1'b1; bus.i_cpu_addr = c_addr; bus.i_cpu_we = c_we; bus.i_cpu_wdata = c_wdata;
        bus.i_rv_req  = 1'b1; bus.i_rv_addr  = r_addr; bus.i_rv_we  = r_we; bus.i_rv_wdata  = r_wdata;
        for (int c = 1; c <= 30 && (cpu_cycle < 0 || rv_cycle < 0); c++) begin
            tick;
            if (c == 1 && toggle) bus.i_wram_load_ongoing = ~load;
            if (bus.o_cpu_ack && bus.o_rv_ack) overlap++;
            if (bus.o_cpu_ack) begin
                cpu_cycle = c; c_rdata = bus.o_cpu_rdata; c_err = bus.o_cpu_err; bus.i_cpu_req = 1'b0;
            end
            if (bus.o_rv_ack) begin
                rv_cycle = c; r_rdata = bus.o_rv_rdata; r_err = bus.o_rv_err; bus.i_rv_req = 1'b0;
            end
        end
        bus.i_cpu_req = 1'b0;
        bus.i_rv_req  = 1'b0;
        bus.i_wram_load_ongoing = 1'b0;
        tick;
    endtask

    initial begin
        logic [7:0] rd, c_rd, r_rd;
        logic       er, c_er, r_er;
        int         lat, cc, rc, ov, n, acks;
        int         seq [10];

        i_reset = 1'b1;
        bus.i_wram_load_ongoing = 1'b0;
        bus.i_cpu_req = 1'b0; bus.i_cpu_addr = '0; bus.i_cpu_we = 1'b0; bus.i_cpu_wdata = '0;
        bus.i_rv_req  = 1'b0; bus.i_rv_addr  = '0; bus.i_rv_we  = 1'b0; bus.i_rv_wdata  = '0;
        tick; tick;
        checkOutput("rst_busy",      bus.o_busy,         0);
        checkOutput("rst_cpu_ack",   bus.o_cpu_ack,      0);
        checkOutput("rst_rv_ack",    bus.o_rv_ack,       0);
        checkOutput("rst_cpu_rdata", bus.o_cpu_rdata,    0);
        checkOutput("rst_rv_rdata",  bus.o_rv_rdata,     0);
        checkOutput("rst_conflict",  bus.o_conflict_cnt, 0);
        i_reset = 1'b0;
        tick;

        // CPU write then RV read of the same WRAM byte
        applyStimulus(1'b0, 23'h6010, 1'b1, 8'hA5, rd, er, lat);
        checkOutput("cpu_wr_lat", lat, 2);
        checkOutput("cpu_wr_err", er, 0);
        applyStimulus(1'b1, 23'h66010, 1'b0, 8'h00, rd, er, lat);
        checkOutput("rv_rd_lat",   lat, 2);
        checkOutput("rv_rd_rdata", rd, 8'hA5);
        checkOutput("rv_rd_err",   er, 0);

        // Simultaneous requests, CPU priority
        runBoth(1'b0, 1'b0, 16'h6010, 1'b0, 8'h00, 23'h66011, 1'b1, 8'h5A, cc, rc, c_rd, r_rd, c_er, r_er, ov);
        checkOutput("both_cpu_cycle", cc, 2);
        checkOutput("both_rv_cycle",  rc, 5);
        checkOutput("both_cpu_rdata", c_rd, 8'hA5);
        checkOutput("both_rv_err",    r_er, 0);
        checkOutput("both_overlap",   ov, 0);
        checkOutput("both_conflict",  bus.o_conflict_cnt, (STATS != 0) ? 1 : 0);

        // Both hold requests continuously: fairness after WAIT_LIMIT losses
        bus.i_cpu_req = 1'b1; bus.i_cpu_addr = 16'h6010;  bus.i_cpu_we = 1'b0;
        bus.i_rv_req  = 1'b1; bus.i_rv_addr  = 23'h66011; bus.i_rv_we  = 1'b0;
        for (int i = 0; i < 10; i++) seq[i] = 2;
        n = 0; ov = 0;
        for (int c = 0; c < 60 && n < 10; c++) begin
            tick;
            if (bus.o_cpu_ack && bus.o_rv_ack) ov++;
            if (bus.o_cpu_ack && n < 10) begin seq[n] = 0; n++; end
            if (bus.o_rv_ack && n < 10) begin seq[n] = 1; n++; end
        end
        c_rd = bus.o_cpu_rdata;
        r_rd = bus.o_rv_rdata;
        bus.i_cpu_req = 1'b0;
        bus.i_rv_req  = 1'b0;
        tick;
        for (int i = 0; i < 10; i++)
            checkOutput($sformatf("grant%0d", i), seq[i], (i % 5 == 4) ? 1 : 0);
        checkOutput("fair_overlap",   ov, 0);
        checkOutput("fair_cpu_rdata", c_rd, 8'hA5);
        checkOutput("fair_rv_rdata",  r_rd, 8'h5A);
        checkOutput("fair_conflict",  bus.o_conflict_cnt, (STATS != 0) ? 11 : 0);

        // Window boundaries and out-of-window errors
        applyStimulus(1'b0, 23'h6000, 1'b1, 8'h42, rd, er, lat);
        checkOutput("wr6000_err", er, 0);
        applyStimulus(1'b0, 23'h8000, 1'b0, 8'h00, rd, er, lat);
        checkOutput("cpu8000_lat",   lat, 2);
        checkOutput("cpu8000_err",   er, 1);
        checkOutput("cpu8000_rdata", rd, 8'hFF);
        applyStimulus(1'b0, 23'h5FFF, 1'b0, 8'h00, rd, er, lat);
        checkOutput("cpu5fff_err", er, 1);
        applyStimulus(1'b1, 23'h68000, 1'b1, 8'h77, rd, er, lat);
        checkOutput("rv68000_lat", lat, 2);
        checkOutput("rv68000_err", er, 1);
        applyStimulus(1'b0, 23'h7FFF, 1'b1, 8'h99, rd, er, lat);
        checkOutput("cpu7fff_err", er, 0);
        applyStimulus(1'b1, 23'h66000, 1'b0, 8'h00, rd, er, lat);
        checkOutput("off0_rdata", rd, 8'h42);
        applyStimulus(1'b1, 23'h67FFF, 1'b0, 8'h00, rd, er, lat);
        checkOutput("rv67fff_rdata", rd, 8'h99);
        checkOutput("rv67fff_err",   er, 0);

        // Reset during ACCESS of an RV write
        bus.i_rv_req = 1'b1; bus.i_rv_addr = 23'h66000; bus.i_rv_we = 1'b1; bus.i_rv_wdata = 8'h3C;
        tick;
        checkOutput("busy_access", bus.o_busy, 1);
        i_reset = 1'b1;
        #1;
        bus.i_rv_req = 1'b0;
        bus.i_rv_we  = 1'b0;
        checkOutput("busy_async_rst", bus.o_busy, 0);
        acks = 0;
        repeat (3) begin tick; if (bus.o_rv_ack || bus.o_cpu_ack) acks++; end
        i_reset = 1'b0;
        repeat (3) begin tick; if (bus.o_rv_ack || bus.o_cpu_ack) acks++; end
        checkOutput("rst_no_ack",      acks, 0);
        checkOutput("rst_busy_after",  bus.o_busy, 0);
        checkOutput("rst_rv_rdata2",   bus.o_rv_rdata, 0);
        checkOutput("rst_conflict2",   bus.o_conflict_cnt, 0);
        applyStimulus(1'b1, 23'h66000, 1'b0, 8'h00, rd, er, lat);
        checkOutput("rst_prior_value", rd, 8'h42);

        // RV priority, priority flipped mid-access
        runBoth(1'b1, 1'b1, 16'h6000, 1'b0, 8'h00, 23'h67FFF, 1'b0, 8'h00, cc, rc, c_rd, r_rd, c_er, r_er, ov);
        checkOutput("load_rv_cycle",  rc, 2);
        checkOutput("load_cpu_cycle", cc, 5);
        checkOutput("load_rv_rdata",  r_rd, 8'h99);
        checkOutput("load_cpu_rdata", c_rd, 8'h42);
        checkOutput("load_overlap",   ov, 0);
        checkOutput("load_conflict",  bus.o_conflict_cnt, (STATS != 0) ? 1 : 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
